// File: rtl/hart_refill_arb.sv
// Refill-port arbiter: queues per-hart I/D misses, grants one refill at a time.
// Build option HART_REFILL_D_FIRST_EN: within a hart, grant D before I.
module hart_refill_arb #(
   parameter int HART_NUM  = 4,
   parameter int HART_ID_W = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_miss,
   input  logic [HART_NUM-1:0]  i_miss_hstate,
   input  logic                 d_miss,
   input  logic [HART_NUM-1:0]  d_miss_hstate,
   input  logic [HART_NUM-1:0]  flush_hstate,
   output logic                 mem_req,
   output logic [HART_ID_W-1:0] mem_hid,
   output logic                 mem_is_d,
   input  logic                 mem_ack,
   input  logic                 mem_done,
   output logic                 i_cache_fin,
   output logic [HART_NUM-1:0]  i_cache_fin_hstate,
   output logic                 d_cache_fin,
   output logic [HART_NUM-1:0]  d_cache_fin_hstate,
   output logic [HART_NUM-1:0]  wait_hstate
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } state_t;

   localparam logic [HART_NUM-1:0] ONE = {{(HART_NUM-1){1'b0}}, 1'b1};

   state_t               state;
   state_t               state_nxt;
   logic [HART_NUM-1:0]  i_pend;
   logic [HART_NUM-1:0]  d_pend;
   logic [HART_NUM-1:0]  any_pend;
   logic [HART_NUM-1:0]  i_set;
   logic [HART_NUM-1:0]  d_set;
   logic [HART_NUM-1:0]  i_clr;
   logic [HART_NUM-1:0]  d_clr;
   logic [HART_NUM-1:0]  sel_oh;
   logic [HART_NUM-1:0]  hid_oh;
   logic [HART_ID_W-1:0] rr_ptr;
   logic [HART_ID_W-1:0] nxt_ptr;
   logic [HART_ID_W-1:0] sel_hid;
   logic                 sel_found;
   logic                 sel_is_d;
   logic                 grant;
   logic                 done;
   int                   idx;

   assign any_pend = i_pend | d_pend;
   assign sel_oh   = ONE << sel_hid;
   assign hid_oh   = ONE << mem_hid;

   // First pending hart at or above rr_ptr, wrapping
   always_comb begin
      sel_found = 1'b0;
      sel_hid   = '0;
      idx       = 0;
      for (int k = 0; k < HART_NUM; k++) begin
         idx = (int'(rr_ptr) + k) % HART_NUM;
         if (!sel_found && any_pend[idx]) begin
            sel_found = 1'b1;
            sel_hid   = HART_ID_W'(idx);
         end
      end
   end

`ifdef HART_REFILL_D_FIRST_EN
   assign sel_is_d = d_pend[sel_hid];
`else
   assign sel_is_d = ~i_pend[sel_hid];
`endif

   assign grant = (state == IDLE) && sel_found;
   assign done  = ((state == WAIT) && mem_done) ||
                  ((state == REQ) && mem_ack && mem_done);

   assign i_set = i_miss ? i_miss_hstate : '0;
   assign d_set = d_miss ? d_miss_hstate : '0;
   assign i_clr = (grant && !sel_is_d) ? sel_oh : '0;
   assign d_clr = (grant && sel_is_d) ? sel_oh : '0;

   assign nxt_ptr = (mem_hid == HART_ID_W'(HART_NUM - 1)) ?
                    '0 : mem_hid + HART_ID_W'(1);

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (sel_found) state_nxt = REQ;
         REQ:  if (mem_ack) state_nxt = mem_done ? IDLE : WAIT;
         WAIT: if (mem_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // A miss landing on the grant cycle re-arms the bit; flush beats both
   always_ff @(posedge clk) begin
      if (rst) begin
         i_pend             <= '0;
         d_pend             <= '0;
         rr_ptr             <= '0;
         mem_hid            <= '0;
         mem_is_d           <= 1'b0;
         i_cache_fin        <= 1'b0;
         i_cache_fin_hstate <= '0;
         d_cache_fin        <= 1'b0;
         d_cache_fin_hstate <= '0;
      end else begin
         i_pend <= ((i_pend & ~i_clr) | i_set) & ~flush_hstate;
         d_pend <= ((d_pend & ~d_clr) | d_set) & ~flush_hstate;
         if (grant) begin
            mem_hid  <= sel_hid;
            mem_is_d <= sel_is_d;
         end
         if (done) rr_ptr <= nxt_ptr;
         i_cache_fin        <= done && !mem_is_d;
         i_cache_fin_hstate <= (done && !mem_is_d) ? hid_oh : '0;
         d_cache_fin        <= done && mem_is_d;
         d_cache_fin_hstate <= (done && mem_is_d) ? hid_oh : '0;
      end
   end

   assign mem_req     = (state == REQ);
   assign wait_hstate = any_pend | ((state != IDLE) ? hid_oh : '0);

endmodule

// File: tb/tb_hart_refill_arb.sv
// Directed bench for hart_refill_arb.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_hart_refill_arb;

   logic       clk;
   logic       rst;
   logic       i_miss;
   logic [3:0] i_miss_hstate;
   logic       d_miss;
   logic [3:0] d_miss_hstate;
   logic [3:0] flush_hstate;
   logic       mem_req;
   logic [1:0] mem_hid;
   logic       mem_is_d;
   logic       mem_ack;
   logic       mem_done;
   logic       i_cache_fin;
   logic [3:0] i_cache_fin_hstate;
   logic       d_cache_fin;
   logic [3:0] d_cache_fin_hstate;
   logic [3:0] wait_hstate;

   int checks;
   int failures;

`ifdef HART_REFILL_D_FIRST_EN
   localparam bit D_FIRST = 1'b1;
`else
   localparam bit D_FIRST = 1'b0;
`endif

   hart_refill_arb #(
      .HART_NUM (4),
      .HART_ID_W(2)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .i_miss            (i_miss),
      .i_miss_hstate     (i_miss_hstate),
      .d_miss            (d_miss),
      .d_miss_hstate     (d_miss_hstate),
      .flush_hstate      (flush_hstate),
      .mem_req           (mem_req),
      .mem_hid           (mem_hid),
      .mem_is_d          (mem_is_d),
      .mem_ack           (mem_ack),
      .mem_done          (mem_done),
      .i_cache_fin       (i_cache_fin),
      .i_cache_fin_hstate(i_cache_fin_hstate),
      .d_cache_fin       (d_cache_fin),
      .d_cache_fin_hstate(d_cache_fin_hstate),
      .wait_hstate       (wait_hstate)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_fin0(input string tag);
      chk({tag, "_ifin"}, {i_cache_fin, i_cache_fin_hstate}, 0);
      chk({tag, "_dfin"}, {d_cache_fin, d_cache_fin_hstate}, 0);
   endtask

   // Waits for a request, checks it, acks, completes, checks the fin pulse
   task automatic serve(input logic [1:0] hid, input logic is_d);
      int n;
      logic [3:0] oh;
      n  = 0;
      oh = 4'b0001 << hid;
      while (!mem_req && n < 10) begin
         tick();
         n++;
      end
      chk("serve_req", mem_req, 1);
      if (mem_req) begin
         chk("serve_hid", mem_hid, hid);
         chk("serve_is_d", mem_is_d, is_d);
         mem_ack = 1'b1;
         tick();
         mem_ack = 1'b0;
         chk("serve_req_drop", mem_req, 0);
         tick();
         mem_done = 1'b1;
         tick();
         mem_done = 1'b0;
         chk("serve_ifin", {i_cache_fin, i_cache_fin_hstate},
             is_d ? 5'h0 : {1'b1, oh});
         chk("serve_dfin", {d_cache_fin, d_cache_fin_hstate},
             is_d ? {1'b1, oh} : 5'h0);
         tick();
         chk_fin0("serve_fin_end");
      end
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      rst           = 1'b1;
      i_miss        = 1'b0;
      i_miss_hstate = '0;
      d_miss        = 1'b0;
      d_miss_hstate = '0;
      flush_hstate  = '0;
      mem_ack       = 1'b0;
      mem_done      = 1'b0;
      tick();
      tick();
      chk("rst_req", {mem_req, mem_hid, mem_is_d}, 0);
      chk_fin0("rst");
      chk("rst_wait", wait_hstate, 0);
      rst = 1'b0;

      // Single D miss on hart 2
      d_miss = 1'b1; d_miss_hstate = 4'b0100;
      tick();
      d_miss = 1'b0; d_miss_hstate = '0;
      chk("t1_pend", wait_hstate, 4'b0100);
      chk("t1_noreq_yet", mem_req, 0);
      tick();
      chk("t1_req", {mem_req, mem_hid, mem_is_d}, {1'b1, 2'd2, 1'b1});
      chk("t1_wait", wait_hstate, 4'b0100);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("t1_req_low", mem_req, 0);
      tick();
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      chk("t1_dfin", {d_cache_fin, d_cache_fin_hstate}, {1'b1, 4'b0100});
      chk("t1_ifin", {i_cache_fin, i_cache_fin_hstate}, 0);
      chk("t1_wait_clr", wait_hstate, 0);
      tick();
      chk_fin0("t1_pulse_end");

      // rr_ptr is 3: multi-hot I miss on harts 0,3 serves 3 first
      i_miss = 1'b1; i_miss_hstate = 4'b1001;
      tick();
      i_miss = 1'b0; i_miss_hstate = '0;
      chk("t1b_wait", wait_hstate, 4'b1001);
      serve(2'd3, 1'b0);
      serve(2'd0, 1'b0);

      // rr_ptr is 1: hart1 I, hart3 D, then hart0 I
      i_miss = 1'b1; i_miss_hstate = 4'b0010;
      d_miss = 1'b1; d_miss_hstate = 4'b1000;
      tick();
      i_miss_hstate = 4'b0001;
      d_miss = 1'b0; d_miss_hstate = '0;
      tick();
      i_miss = 1'b0; i_miss_hstate = '0;
      chk("t2_wait", wait_hstate, 4'b1011);
      serve(2'd1, 1'b0);
      serve(2'd3, 1'b1);
      serve(2'd0, 1'b0);

      // I and D on hart 0 together
      i_miss = 1'b1; i_miss_hstate = 4'b0001;
      d_miss = 1'b1; d_miss_hstate = 4'b0001;
      tick();
      i_miss = 1'b0; i_miss_hstate = '0;
      d_miss = 1'b0; d_miss_hstate = '0;
      chk("t3_wait_a", wait_hstate, 4'b0001);
      serve(2'd0, D_FIRST);
      chk("t3_wait_b", wait_hstate, 4'b0001);
      serve(2'd0, !D_FIRST);
      chk("t3_wait_c", wait_hstate, 0);

      // Flush hart2 while hart1 is in WAIT
      i_miss = 1'b1; i_miss_hstate = 4'b0110;
      tick();
      i_miss = 1'b0; i_miss_hstate = '0;
      tick();
      chk("t4_req", {mem_req, mem_hid, mem_is_d}, {1'b1, 2'd1, 1'b0});
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("t4_wait_pre", wait_hstate, 4'b0110);
      flush_hstate = 4'b0100;
      tick();
      flush_hstate = '0;
      chk("t4_wait_flush", wait_hstate, 4'b0010);
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      chk("t4_ifin", {i_cache_fin, i_cache_fin_hstate}, {1'b1, 4'b0010});
      tick();
      chk("t4_wait_end", wait_hstate, 0);
      tick();
      chk("t4_no_req", mem_req, 0);

      // Flush beats same-cycle miss; zero hstate is a no-op
      i_miss = 1'b1; i_miss_hstate = 4'b0100; flush_hstate = 4'b0100;
      d_miss = 1'b1; d_miss_hstate = 4'b0000;
      tick();
      i_miss = 1'b0; i_miss_hstate = '0; flush_hstate = '0;
      d_miss = 1'b0;
      chk("t4b_wait", wait_hstate, 0);
      tick();
      chk("t4b_no_req", mem_req, 0);

      // ack+done together in REQ
      d_miss = 1'b1; d_miss_hstate = 4'b0001;
      tick();
      d_miss = 1'b0; d_miss_hstate = '0;
      tick();
      chk("t5_req", {mem_req, mem_hid, mem_is_d}, {1'b1, 2'd0, 1'b1});
      mem_ack = 1'b1; mem_done = 1'b1;
      tick();
      mem_ack = 1'b0; mem_done = 1'b0;
      chk("t5_dfin", {d_cache_fin, d_cache_fin_hstate}, {1'b1, 4'b0001});
      chk("t5_req_low", mem_req, 0);
      tick();
      chk_fin0("t5_pulse_end");
      // Stray done while idle
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      chk_fin0("t5_stray_a");
      tick();
      chk_fin0("t5_stray_b");

      // Reset in WAIT abandons the refill
      i_miss = 1'b1; i_miss_hstate = 4'b1000;
      tick();
      i_miss = 1'b0; i_miss_hstate = '0;
      tick();
      chk("t6_req", {mem_req, mem_hid}, {1'b1, 2'd3});
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_rst_req", {mem_req, mem_hid, mem_is_d}, 0);
      chk_fin0("t6_rst");
      chk("t6_rst_wait", wait_hstate, 0);
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      chk_fin0("t6_late_done");
      tick();
      chk_fin0("t6_late_done_b");
      chk("t6_idle", mem_req, 0);
      d_miss = 1'b1; d_miss_hstate = 4'b0010;
      tick();
      d_miss = 1'b0; d_miss_hstate = '0;
      serve(2'd1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hart_refill_arb.md
# hart_refill_arb

Shared refill-port arbiter for the multithreaded core. It collects I-cache and D-cache miss events tagged with one-hot hart state and holds them as pending requests. It grants the single memory refill port to one request at a time, round-robin across harts. On completion it returns the `i_cache_fin`/`d_cache_fin` pulses, with hart state, that hart_ctrl consumes to reactivate stalled harts.

## Interface
- `HART_NUM`, 4, number of harts; one-hot state width
- `HART_ID_W`, 2, hart id width, log2(`HART_NUM`)
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `i_miss`  in  1  I-cache miss event, sampled every cycle
- `i_miss_hstate`  in  `HART_NUM`  one-hot hart of the I miss
- `d_miss`  in  1  D-cache miss event
- `d_miss_hstate`  in  `HART_NUM`  one-hot hart of the D miss
- `flush_hstate`  in  `HART_NUM`  drop not-yet-granted requests of these harts
- `mem_req`  out  1  refill request to memory
- `mem_hid`  out  `HART_ID_W`  hart id of the request
- `mem_is_d`  out  1  1 = D-cache refill, 0 = I-cache refill
- `mem_ack`  in  1  memory accepted `mem_req`
- `mem_done`  in  1  refill data returned
- `i_cache_fin`  out  1  one-cycle I refill complete pulse
- `i_cache_fin_hstate`  out  `HART_NUM`  one-hot hart of `i_cache_fin`
- `d_cache_fin`  out  1  one-cycle D refill complete pulse
- `d_cache_fin_hstate`  out  `HART_NUM`  one-hot hart of `d_cache_fin`
- `wait_hstate`  out  `HART_NUM`  harts with any pending or in-service refill
- One clock; reset is synchronous and active-high.

## Operation
- State: `i_pend[HART_NUM]`, `d_pend[HART_NUM]`, `rr_ptr[HART_ID_W]`, FSM {IDLE, REQ, WAIT}, and a registered grant (`mem_hid`, `mem_is_d`).
- Capture: on `i_miss`, OR `i_miss_hstate` into `i_pend`. On `d_miss`, OR `d_miss_hstate` into `d_pend`.
  - Multi-hot input sets every flagged bit.
  - A zero hstate is a no-op.
  - Setting an already-set bit is a no-op (no duplicate refill).
- Flush: clear `i_pend` and `d_pend` bits under `flush_hstate`.
  - Flush wins over a same-cycle miss set for that hart.
  - Flush does not affect the request currently in REQ/WAIT.
- IDLE: if any pending bit is set, select a hart by scanning from `rr_ptr` upward, wrapping modulo `HART_NUM`.
  - The selected hart is the first with `i_pend|d_pend` set.
  - Within that hart, I is chosen before D (see Configuration).
  - Register the grant, clear its pending bit, and go to REQ.
- REQ: `mem_req`=1, with `mem_hid` and `mem_is_d` held stable.
  - On `mem_ack`, go to WAIT.
  - `mem_ack` and `mem_done` in the same REQ cycle count as completion; go straight to IDLE.
- WAIT: on `mem_done`:
  - Pulse the matching fin output with `1<<mem_hid` for exactly one cycle.
  - Set `rr_ptr` = `mem_hid`+1 (wraps 3→0).
  - Return to IDLE.
- `mem_done` outside WAIT, or outside REQ+ack, is ignored. `mem_ack` outside REQ is ignored.
- A new miss for the in-service hart and type re-sets its pending bit, which produces a second refill later.
- `wait_hstate` = `i_pend | d_pend | (in-service hart, one-hot, in REQ/WAIT)`.
- Fin hstate outputs are 0 whenever their fin bit is 0.

## Timing
- Reset: FSM=IDLE; `i_pend`, `d_pend`, `rr_ptr` = 0; all outputs 0. Reset mid-transaction abandons it; no fin pulse is issued.
- Miss pulse in cycle 0: the pending bit is visible in cycle 1, and `mem_req` is high in cycle 2 if the arbiter is idle.
- `mem_ack` in cycle n: `mem_req` is low from cycle n+1.
- `mem_done` in cycle m (WAIT): fin is high in cycle m+1 only, and FSM=IDLE in m+1.
- Next `mem_req` can rise in cycle m+2. Minimum grant spacing is 1 idle cycle.
- The arbiter is fully registered: no combinational path from `mem_ack`/`mem_done` to `mem_req`.
- I and D fin never assert in the same cycle.

## Configuration
- `HART_REFILL_D_FIRST_EN` defined: within the selected hart, D is granted before I. This shortens load-miss stalls.
- Undefined: I is granted before D.
- The round-robin over harts is identical in both builds.

## Test plan
- After reset, `d_miss`, `d_miss_hstate`=0100 → `mem_req`=1, `mem_hid`=2, `mem_is_d`=1 two cycles later. `mem_ack` then `mem_done` → `d_cache_fin`=1, `d_cache_fin_hstate`=0100 for one cycle; `rr_ptr`=3.
- With `rr_ptr`=0, `i_miss` hstate 0010 and `d_miss` hstate 1000 in the same cycle, then `i_miss` 0001 → grant order hart1(I), hart3(D), hart0(I). Each completes with the correct fin hstate.
- `i_miss` and `d_miss` both hstate 0001 in the same cycle → I served first (D first when `HART_REFILL_D_FIRST_EN`), then the other. `wait_hstate`=0001 until the second fin.
- Pending for harts 1 and 2, `flush_hstate`=0100 while hart1 is in WAIT → hart1 completes normally, no hart2 request is issued, and `wait_hstate`=0000 after the fin.
- Assert `mem_ack`+`mem_done` in the same REQ cycle → fin next cycle. A stray `mem_done` in IDLE → no fin.
- `rst` asserted during WAIT → all outputs 0 next cycle. A later `mem_done` produces no fin; the next miss is served normally.
